// File: rtl/sos_frame_ctrl.sv
// Frame sequencer for the sos_cache 3x3 line buffer: forwards one frame of cells,
// counts returned window_valid pulses and flags completion, count errors and aborts.
module sos_frame_ctrl #(
    parameter int unsigned TOTAL_BIT_WIDTH = 35,
    parameter int unsigned FRAME_W         = 34,
    parameter int unsigned FRAME_H         = 34,
    parameter int unsigned CNT_W           = 11,
    parameter int unsigned DRAIN_CYC       = 4
) (
    input  logic                       aclk,
    input  logic                       arest,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [TOTAL_BIT_WIDTH-1:0] s_data,
    input  logic                       dn_ready,
    output logic                       sos_valid,
    output logic [TOTAL_BIT_WIDTH-1:0] sum_of_squares,
    output logic                       cache_rst_n,
    input  logic                       window_valid,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       win_err,
    output logic                       aborted,
    output logic [CNT_W-1:0]           win_cnt
);

    localparam int unsigned TBW     = TOTAL_BIT_WIDTH;
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYC + 1);

    localparam logic [CNT_W-1:0]   LAST_CELL  = CNT_W'(FRAME_W * FRAME_H - 1);
    localparam logic [CNT_W-1:0]   WIN_EXP    = CNT_W'((FRAME_W - 2) * (FRAME_H - 2));
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cell_cnt_q, cell_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic               win_err_q, win_err_d;
    logic               sos_valid_q, sos_valid_d;
    logic [TBW-1:0]     sos_data_q, sos_data_d;
    logic               frame_done_q, frame_done_d;
    logic               aborted_q, aborted_d;
    logic               busy_q, busy_d;
    logic               crst_n_q, crst_n_d;
    logic               crst_hold_q, crst_hold_d;

    logic               xfer;
    logic               win_hit;
    logic [CNT_W-1:0]   win_cnt_inc;

    assign s_ready     = (state_q == ST_RUN) & dn_ready & crst_n_q;
    assign xfer        = s_valid & s_ready;
    assign win_hit     = window_valid & ((state_q == ST_RUN) | (state_q == ST_DRAIN));
    assign win_cnt_inc = (win_hit && (win_cnt_q != '1)) ? win_cnt_q + CNT_W'(1) : win_cnt_q;

    // Next-state and registered-output logic; abort overrides everything below it.
    always_comb begin
        state_d      = state_q;
        cell_cnt_d   = cell_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        sos_valid_d  = 1'b0;
        sos_data_d   = sos_data_q;
        frame_done_d = 1'b0;
        aborted_d    = 1'b0;
        crst_n_d     = ~crst_hold_q;
        crst_hold_d  = 1'b0;

        if (xfer) begin
            sos_valid_d = 1'b1;
            sos_data_d  = s_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    cell_cnt_d  = '0;
                    drain_cnt_d = '0;
                    win_cnt_d   = '0;
                    win_err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                win_cnt_d = win_cnt_inc;
                if (xfer) begin
                    cell_cnt_d = cell_cnt_q + CNT_W'(1);
                    if (cell_cnt_q == LAST_CELL) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                win_cnt_d   = win_cnt_inc;
                drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d      = ST_DONE;
                    win_err_d    = (win_cnt_inc != WIN_EXP);
                    frame_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Hold the cache in reset for two cycles so its cell counter realigns.
        if (abort) begin
            state_d      = ST_IDLE;
            win_cnt_d    = '0;
            sos_valid_d  = 1'b0;
            sos_data_d   = sos_data_q;
            frame_done_d = 1'b0;
            aborted_d    = 1'b1;
            crst_n_d     = 1'b0;
            crst_hold_d  = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge aclk or posedge arest) begin
        if (arest) begin
            state_q      <= ST_IDLE;
            cell_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= 1'b0;
            sos_valid_q  <= 1'b0;
            sos_data_q   <= '0;
            frame_done_q <= 1'b0;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
            crst_n_q     <= 1'b0;
            crst_hold_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cell_cnt_q   <= cell_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            sos_valid_q  <= sos_valid_d;
            sos_data_q   <= sos_data_d;
            frame_done_q <= frame_done_d;
            aborted_q    <= aborted_d;
            busy_q       <= busy_d;
            crst_n_q     <= crst_n_d;
            crst_hold_q  <= crst_hold_d;
        end
    end

    assign sos_valid      = sos_valid_q;
    assign sum_of_squares = sos_data_q;
    assign cache_rst_n    = crst_n_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign win_err        = win_err_q;
    assign aborted        = aborted_q;
    assign win_cnt        = win_cnt_q;

endmodule

// File: tb/tb_sos_frame_ctrl.sv
// Self-checking bench for sos_frame_ctrl: random cell stream, an ideal raster cache
// model generating window_valid, and frame-level expectations derived from frame geometry.
module tb_sos_frame_ctrl;

    localparam int unsigned TBW      = 35;
    localparam int unsigned FW       = 34;
    localparam int unsigned FH       = 34;
    localparam int unsigned CNT_W    = 11;
    localparam int unsigned CELLS    = FW * FH;
    localparam int unsigned WIN_FULL = (FW - 2) * (FH - 2);
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;
    localparam int          BUDGET   = 8000;

    logic             aclk;
    logic             arest;
    logic             start;
    logic             abort;
    logic             s_valid;
    logic             s_ready;
    logic [TBW-1:0]   s_data;
    logic             dn_ready;
    logic             sos_valid;
    logic [TBW-1:0]   sum_of_squares;
    logic             cache_rst_n;
    logic             window_valid;
    logic             busy;
    logic             frame_done;
    logic             win_err;
    logic             aborted;
    logic [CNT_W-1:0] win_cnt;

    sos_frame_ctrl dut (
        .aclk           (aclk),
        .arest          (arest),
        .start          (start),
        .abort          (abort),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .dn_ready       (dn_ready),
        .sos_valid      (sos_valid),
        .sum_of_squares (sum_of_squares),
        .cache_rst_n    (cache_rst_n),
        .window_valid   (window_valid),
        .busy           (busy),
        .frame_done     (frame_done),
        .win_err        (win_err),
        .aborted        (aborted),
        .win_cnt        (win_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic [TBW-1:0]   src_q[$];
    logic [TBW-1:0]   exp_q[$];
    int               n_cmp;
    int               n_fail;
    int               n_sos, data_err, seq_err, stall_err, stall_low;
    int               fd_seen, ab_seen, crst_low, frame_xfers;
    int               stall_left, drop_left, c_idx;
    logic [CNT_W-1:0] fd_win;
    logic             fd_err;
    bit               prev_push, dense, last_sos;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_sos = 0; data_err = 0; seq_err = 0; stall_err = 0; stall_low = 0;
        fd_seen = 0; ab_seen = 0; crst_low = 0; frame_xfers = 0;
        fd_win = '0; fd_err = 1'b0;
    endtask

    // One clock cycle: observe outputs, run the cache model, drive upstream, record transfer.
    task automatic cycle(input bit st = 1'b0, input bit ab = 1'b0, input bit inj = 1'b0);
        logic [TBW-1:0] e;
        logic [63:0]    r;
        bit             win;
        bit             stall_now;
        @(negedge aclk);
        if (!cache_rst_n) crst_low++;
        if (aborted) ab_seen++;
        if (frame_done) begin
            fd_seen++;
            fd_win = win_cnt;
            fd_err = win_err;
        end
        last_sos = sos_valid;
        if (sos_valid !== prev_push) seq_err++;
        if (sos_valid) begin
            n_sos++;
            if (exp_q.size() == 0) data_err++;
            else begin
                e = exp_q.pop_front();
                if (e !== sum_of_squares) data_err++;
            end
        end
        // ideal cache: a window completes on every cell with row>=2 and col>=2
        win = 1'b0;
        if (!cache_rst_n) c_idx = 0;
        else if (sos_valid) begin
            if ((c_idx % FW) >= 2 && (c_idx / FW) >= 2) win = 1'b1;
            c_idx = (c_idx == int'(CELLS) - 1) ? 0 : c_idx + 1;
        end
        if (win && drop_left > 0) begin
            win = 1'b0;
            drop_left--;
        end
        if (inj) win = 1'b1;
        window_valid = win;
        start = st;
        abort = ab;
        stall_now = (stall_left != 0);
        dn_ready = !stall_now;
        if (stall_left != 0) stall_left--;
        while (src_q.size() < 4) begin
            r = {$urandom, $urandom};
            src_q.push_back(r[TBW-1:0]);
        end
        s_valid = dense || ($urandom_range(0, 3) == 0);
        s_data = src_q[0];
        #1;
        prev_push = 1'b0;
        if (stall_now) begin
            if (s_ready) stall_err++;
            else stall_low++;
        end
        if (s_valid && s_ready) begin
            void'(src_q.pop_front());
            frame_xfers++;
            if (!ab) begin
                exp_q.push_back(s_data);
                prev_push = 1'b1;
            end
        end
    endtask

    task automatic run_frame(input int stall_at, input int abort_at, input int restart_at,
                             input int drop, input bit dense_i, input bit inj_all);
        int cyc;
        bit st, ab, stalled, ab_done, rs_done;
        clear_stats();
        dense = dense_i;
        drop_left = drop;
        stalled = 0; ab_done = 0; rs_done = 0;
        cycle(1'b1, 1'b0, inj_all);
        cyc = 0;
        while (fd_seen == 0 && ab_seen == 0 && cyc < BUDGET) begin
            st = 0; ab = 0;
            if (!stalled && stall_at >= 0 && frame_xfers >= stall_at) begin
                stall_left = 10;
                stalled = 1;
            end
            if (!ab_done && abort_at >= 0 && frame_xfers >= abort_at) begin
                ab = 1;
                ab_done = 1;
            end
            if (!rs_done && restart_at >= 0 && frame_xfers >= restart_at) begin
                st = 1;
                rs_done = 1;
            end
            cycle(st, ab, inj_all);
            cyc++;
        end
        chk("frame_within_budget", 64'(cyc < BUDGET), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int exp_win, input bit exp_err);
        repeat (2) cycle();
        chk({tag, "_sos_pulses"}, 64'(n_sos), 64'(CELLS));
        chk({tag, "_done_cycles"}, 64'(fd_seen), 64'd1);
        chk({tag, "_win_at_done"}, 64'(fd_win), 64'(exp_win));
        chk({tag, "_win_err"}, 64'(fd_err), 64'(exp_err));
        chk({tag, "_win_cnt_held"}, 64'(win_cnt), 64'(exp_win));
        chk({tag, "_data_order"}, 64'(data_err), 64'd0);
        chk({tag, "_sos_timing"}, 64'(seq_err), 64'd0);
        chk({tag, "_no_leftover"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        arest = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        dn_ready = 1'b1; window_valid = 1'b0;
        stall_left = 0; drop_left = 0; c_idx = 0; prev_push = 1'b0; dense = 1'b1;
        clear_stats();

        // reset values
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_sos_valid", 64'(sos_valid), 64'd0);
        chk("rst_sos_data", 64'(sum_of_squares), 64'd0);
        chk("rst_cache_rst_n", 64'(cache_rst_n), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outputs", 64'({frame_done, win_err, aborted}), 64'd0);
        chk("rst_win_cnt", 64'(win_cnt), 64'd0);
        @(negedge aclk);
        arest = 1'b0;
        #1;
        chk("release_crst_low", 64'(cache_rst_n), 64'd0);
        cycle();
        chk("release_crst_high", 64'(cache_rst_n), 64'd1);
        chk("idle_s_ready", 64'(s_ready), 64'd0);

        // full frame, back-to-back cells
        run_frame(-1, -1, -1, 0, 1'b1, 1'b0);
        check_frame("t1", WIN_FULL, 1'b0);

        // consumer stall of 10 cycles mid-row
        run_frame(int'($urandom_range(490, 510)), -1, -1, 0, 1'b1, 1'b0);
        chk("t2_stall_ready_low", 64'(stall_low), 64'd10);
        chk("t2_stall_ready_high", 64'(stall_err), 64'd0);
        check_frame("t2", WIN_FULL, 1'b0);

        // sparse random upstream valid
        run_frame(-1, -1, -1, 0, 1'b0, 1'b0);
        check_frame("t2r", WIN_FULL, 1'b0);

        // one window pulse missing
        run_frame(-1, -1, -1, 1, 1'b1, 1'b0);
        check_frame("t3", WIN_FULL - 1, 1'b1);

        // abort at cell 700, then a clean frame
        run_frame(-1, 700, -1, 0, 1'b1, 1'b0);
        chk("t4_sos_stops", 64'(last_sos), 64'd0);
        repeat (4) cycle();
        chk("t4_crst_low_cycles", 64'(crst_low), 64'd2);
        chk("t4_aborted_pulses", 64'(ab_seen), 64'd1);
        chk("t4_no_frame_done", 64'(fd_seen), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_win_cnt_cleared", 64'(win_cnt), 64'd0);
        chk("t4_sos_timing", 64'(seq_err), 64'd0);
        chk("t4_data_order", 64'(data_err), 64'd0);
        run_frame(-1, -1, -1, 0, 1'b1, 1'b0);
        check_frame("t4b", WIN_FULL, 1'b0);

        // start+abort together in IDLE; then start ignored during RUN
        repeat (2) cycle();
        clear_stats();
        cycle(1'b1, 1'b1, 1'b0);
        cycle();
        chk("t5_busy_stays_low", 64'(busy), 64'd0);
        chk("t5_aborted_pulse", 64'(ab_seen), 64'd1);
        repeat (3) cycle();
        run_frame(-1, -1, 300, 0, 1'b1, 1'b0);
        check_frame("t5", WIN_FULL, 1'b0);

        // window count saturation
        run_frame(-1, -1, -1, 0, 1'b0, 1'b1);
        check_frame("sat", CNT_MAX, 1'b1);

        // asynchronous reset mid-RUN
        clear_stats();
        dense = 1'b1;
        cycle(1'b1);
        for (int i = 0; i < BUDGET && frame_xfers < 400; i++) cycle();
        @(negedge aclk);
        arest = 1'b1;
        #1;
        chk("t6_rst_s_ready", 64'(s_ready), 64'd0);
        chk("t6_rst_sos_valid", 64'(sos_valid), 64'd0);
        chk("t6_rst_sos_data", 64'(sum_of_squares), 64'd0);
        chk("t6_rst_cache_rst_n", 64'(cache_rst_n), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_win_cnt", 64'(win_cnt), 64'd0);
        exp_q.delete();
        prev_push = 1'b0;
        c_idx = 0;
        start = 1'b0; abort = 1'b0; window_valid = 1'b0;
        repeat (2) @(negedge aclk);
        arest = 1'b0;
        #1;
        chk("t6_release_crst_low", 64'(cache_rst_n), 64'd0);
        cycle();
        chk("t6_release_crst_high", 64'(cache_rst_n), 64'd1);
        chk("t6_s_ready_until_start", 64'(s_ready), 64'd0);
        repeat (2) cycle();
        run_frame(-1, -1, -1, 0, 1'b1, 1'b0);
        check_frame("t6", WIN_FULL, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
